// File: rtl/regfile_mp.sv
// regfile_mp: parametrised N-read / M-write integer register file with
// same-cycle write-to-read bypass and a per-register busy scoreboard.
// Decode allocates destinations (sets busy), writeback clears them.
module regfile_mp #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int NRD     = 2,
    parameter int NWR     = 2,
    parameter bit BYPASS  = 1'b1,
    parameter bit ZERO_R0 = 1'b1,
    localparam int AW     = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic [NWR-1:0]      wen,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    output logic                any_busy
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;

    // An address names real, writable/trackable state: in range and not a
    // hard-wired zero register.
    function automatic logic live(input logic [AW-1:0] a);
        live = ({1'b0, a} < (AW+1)'(NREG)) && !(ZERO_R0 && (a == '0));
    endfunction

    // State update: writes in ascending port order so the highest port wins
    // a same-address conflict; alloc is applied last so a new producer
    // overrides a same-cycle writeback clearing the busy bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            busy <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wen[j] && live(waddr[j*AW +: AW])) begin
                    regs[waddr[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
                    busy[waddr[j*AW +: AW]] <= 1'b0;
                end
            end
            if (alloc_en && live(alloc_addr))
                busy[alloc_addr] <= 1'b1;
        end
    end

    assign any_busy = |busy;

    // Read ports: combinational lookup of stored state, optionally overridden
    // by the highest-indexed same-cycle write to the same register.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            b;

        assign a = raddr[k*AW +: AW];

        // Per-port read mux with bypass.
        always_comb begin
            d = '0;
            b = 1'b0;
            if (live(a)) begin
                d = regs[a];
                b = busy[a];
                if (BYPASS) begin
                    for (int j = 0; j < NWR; j++) begin
                        if (wen[j] && (waddr[j*AW +: AW] == a)) begin
                            d = wdata[j*XLEN +: XLEN];
                            b = alloc_en && (alloc_addr == a);
                        end
                    end
                end
            end
        end

        assign rdata[k*XLEN +: XLEN] = d;
        assign rbusy[k]              = b;
    end

endmodule
